byte_reorder_restore: RTL

//  Receive-side partner of the 9-phase byte reorder (scramble) stage.
//  - Input is a byte stream whose order was permuted within fixed 9-byte frames.
//  - Function: buffer each frame, then emit its bytes in original order 0..8.
//  - Placement: sits on the far side of the link, directly downstream of the scrambled stream.

---
 rtl/byte_reorder_restore_pkg.sv | 15 +
 rtl/byte_reorder_restore_if.sv | 10 +
 rtl/byte_reorder_restore_frame_pingpong_buf.sv | 39 +++
 rtl/byte_reorder_restore.sv | 113 +++++++++++
 4 files changed

// File: rtl/byte_reorder_restore_pkg.sv
// Shared constants for the 9-phase byte scrambler and its restore partner.
// SRC_IDX[p] is the original byte index carried at scrambled position p.
package byte_reorder_pkg;
  localparam int FRAME_LEN = 9;
  localparam int DATA_W    = 8;
  localparam int POS_W     = 4;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

  localparam logic [0:FRAME_LEN-1][POS_W-1:0] SRC_IDX =
    {4'd1, 4'd0, 4'd3, 4'd2, 4'd5, 4'd4, 4'd7, 4'd6, 4'd8};

  typedef enum logic {WR_HUNT = 1'b0, WR_FILL = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_DRAIN = 1'b1} rd_state_e;
endpackage

// File: rtl/byte_reorder_restore_if.sv
// Byte stream with start-of-frame marker; master drives, slave receives.
interface byte_reorder_restore_if;
  import byte_reorder_pkg::*;
  logic              valid;
  logic              sof;
  logic [DATA_W-1:0] data;

  modport master (output valid, sof, data);
  modport slave  (input  valid, sof, data);
endinterface

// File: rtl/byte_reorder_restore_frame_pingpong_buf.sv
// Two 9-byte frame banks with per-bank full flags; writer sets, reader clears.
module frame_pingpong_buf
  import byte_reorder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb,
  input  logic [POS_W-1:0]  waddr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rb,
  input  logic [POS_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              set_full,
  input  logic              clr_full,
  output logic [1:0]        full
);
  logic [DATA_W-1:0] mem_q [2][FRAME_LEN];
  logic [1:0]        full_q, full_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[wb][waddr] <= wdata;
  end

  assign rdata = mem_q[rb][raddr];

  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rb] = 1'b0;
    if (set_full) full_d[wb] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= '0;
    else     full_q <= full_d;
  end

  assign full = full_q;
endmodule

// File: rtl/byte_reorder_restore.sv
// Restores original byte order of 9-byte scrambled frames via a ping-pong buffer;
// writer FSM fills one bank while reader FSM drains the other.
module byte_reorder_restore
  import byte_reorder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  byte_reorder_restore_if.slave   in_s,
  byte_reorder_restore_if.master  out_m,
  output logic                    err_sync
);
  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [POS_W-1:0]  wr_pos_q, wr_pos_d, rd_pos_q, rd_pos_d, wpos, waddr;
  logic              wb_q, wb_d, rb_q, rb_d;
  logic              accept, emit, set_full, clr_full;
  logic [1:0]        full;
  logic [DATA_W-1:0] rdata;
  logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, err_q, err_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  frame_pingpong_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb_q),
    .waddr    (waddr),
    .we       (accept),
    .wdata    (in_s.data),
    .rb       (rb_q),
    .raddr    (rd_pos_q),
    .rdata    (rdata),
    .set_full (set_full),
    .clr_full (clr_full),
    .full     (full)
  );

  // A sof byte always restarts at position 0, whether hunting or resyncing.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_pos_d   = wr_pos_q;
    wb_d       = wb_q;
    err_d      = 1'b0;
    set_full   = 1'b0;
    accept     = in_s.valid && (in_s.sof || wr_state_q == WR_FILL);
    wpos       = (in_s.sof || wr_state_q == WR_HUNT) ? '0 : wr_pos_q;
    waddr      = SRC_IDX[wpos];
    if (accept) begin
      wr_state_d = WR_FILL;
      err_d      = in_s.sof && wr_state_q == WR_FILL && wr_pos_q != '0;
      if (wpos == LAST_POS) begin
        set_full = 1'b1;
        wb_d     = ~wb_q;
        wr_pos_d = '0;
      end else begin
        wr_pos_d = wpos + 1'b1;
      end
    end
  end

  // The bank being filled this cycle counts as ready so back-to-back frames drain gaplessly.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_pos_d    = rd_pos_q;
    rb_d        = rb_q;
    clr_full    = 1'b0;
    emit        = rd_state_q == RD_DRAIN || full[rb_q];
    out_valid_d = emit;
    out_sof_d   = emit && rd_pos_q == '0;
    out_data_d  = emit ? rdata : '0;
    if (emit) begin
      rd_state_d = RD_DRAIN;
      if (rd_pos_q == LAST_POS) begin
        clr_full = 1'b1;
        rb_d     = ~rb_q;
        rd_pos_d = '0;
        if (!(full[~rb_q] || (set_full && wb_q != rb_q))) rd_state_d = RD_IDLE;
      end else begin
        rd_pos_d = rd_pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WR_HUNT;
      rd_state_q  <= RD_IDLE;
      wr_pos_q    <= '0;
      rd_pos_q    <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_pos_q    <= wr_pos_d;
      rd_pos_q    <= rd_pos_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_m.valid = out_valid_q;
  assign out_m.sof   = out_sof_q;
  assign out_m.data  = out_data_q;
  assign err_sync    = err_q;
endmodule
